// File: rtl/rf_pkg.sv
// Shared constants, address type and counter-width helper for the
// register file and its busy scoreboard.
package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // Wide enough to hold every value from 0 to num_regs inclusive.
  function automatic int busy_cnt_w(input int num_regs);
    return $clog2(num_regs + 1);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for multi-cycle producers.
// Also produces a registered count of how many registers are busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = busy_cnt_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_cnt
);

  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;

  // Per-bit priority: flush clears all, then a claim sets, then a write clears.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_d[i] = !flush &&
                  ((claim_en && (claim_addr == ADDR_W'(i))) ||
                   (busy_q[i] && !(wr_en && (wr_addr == ADDR_W'(i)))));
    end
    busy_d[0] = busy_d[0] & (ZERO_REG == 0);
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Busy vector and its popcount advance together on each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NUM_REGS{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass and a busy scoreboard for RAW detection.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDR_W-1:0]                 rd_addr_1,
  output logic [DATA_W-1:0]                 rd_data_1,
  output logic                              rd_busy_1,
  input  logic [ADDR_W-1:0]                 rd_addr_2,
  output logic [DATA_W-1:0]                 rd_data_2,
  output logic                              rd_busy_2,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              claim_en,
  input  logic [ADDR_W-1:0]                 claim_addr,
  input  logic                              flush,
  output logic [busy_cnt_w(NUM_REGS)-1:0]   busy_cnt
);

  localparam int CNT_W = busy_cnt_w(NUM_REGS);

  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;
  logic                wr_ok_s;

  assign wr_ok_s = wr_en && !((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}}));

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy       (busy_s),
    .busy_cnt   (busy_cnt)
  );

  // Next-state data array; flush does not block writes.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok_s) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d[wr_addr] = regs_q[wr_addr];
    end
  end

  // Data array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: forwarded write data reports not-busy even if reclaimed.
  always_comb begin
    rd_data_1 = regs_q[rd_addr_1];
    rd_busy_1 = busy_s[rd_addr_1];
    if ((ZERO_REG != 0) && (rd_addr_1 == {ADDR_W{1'b0}})) begin
      rd_data_1 = {DATA_W{1'b0}};
      rd_busy_1 = 1'b0;
    end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr_1)) begin
      rd_data_1 = wr_data;
      rd_busy_1 = 1'b0;
    end else begin
      rd_data_1 = regs_q[rd_addr_1];
      rd_busy_1 = busy_s[rd_addr_1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd_data_2 = regs_q[rd_addr_2];
    rd_busy_2 = busy_s[rd_addr_2];
    if ((ZERO_REG != 0) && (rd_addr_2 == {ADDR_W{1'b0}})) begin
      rd_data_2 = {DATA_W{1'b0}};
      rd_busy_2 = 1'b0;
    end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == rd_addr_2)) begin
      rd_data_2 = wr_data;
      rd_busy_2 = 1'b0;
    end else begin
      rd_data_2 = regs_q[rd_addr_2];
      rd_busy_2 = busy_s[rd_addr_2];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a vector table through a scoreboard
// queue plus hand sequences for reset, busy_cnt range and bypass off.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_addr_1, rd_addr_2, wr_addr, claim_addr;
  logic [15:0] wr_data;
  logic        wr_en, claim_en, flush;
  logic [15:0] rd_data_1, rd_data_2, nb_data_1, nb_data_2;
  logic        rd_busy_1, rd_busy_2, nb_busy_1, nb_busy_2;
  logic [3:0]  busy_cnt, nb_busy_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        ce;
    logic [2:0]  ca;
    logic        fl;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] d1;
    logic        b1;
    logic [15:0] d2;
    logic        b2;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [17];
  vec_t sb_q [$];

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_busy_1(rd_busy_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_busy_2(rd_busy_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_data_1(nb_data_1), .rd_busy_1(nb_busy_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(nb_data_2), .rd_busy_2(nb_busy_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
    .busy_cnt(nb_busy_cnt)
  );

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                              input logic ce, input logic [2:0] ca, input logic fl,
                              input logic [2:0] ra1, input logic [2:0] ra2,
                              input logic [15:0] d1, input logic b1,
                              input logic [15:0] d2, input logic b2, input logic [3:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ce = ce; v.ca = ca; v.fl = fl;
    v.ra1 = ra1; v.ra2 = ra2; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    claim_en = 1'b0; claim_addr = 3'd0; flush = 1'b0;
  endtask

  // Drive just after a posedge, check reads mid-cycle, check busy_cnt after the edge.
  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    claim_en = v.ce; claim_addr = v.ca; flush = v.fl;
    rd_addr_1 = v.ra1; rd_addr_2 = v.ra2;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    check("rd_data_1", idx, rd_data_1, e.d1);
    check("rd_busy_1", idx, {15'd0, rd_busy_1}, {15'd0, e.b1});
    check("rd_data_2", idx, rd_data_2, e.d2);
    check("rd_busy_2", idx, {15'd0, rd_busy_2}, {15'd0, e.b2});
    @(posedge clk);
    #1;
    check("busy_cnt", idx, {12'd0, busy_cnt}, {12'd0, e.cnt});
  endtask

  initial begin
    //              we    wa    wd        ce    ca    fl    ra1   ra2   d1        b1    d2        b2    cnt
    tbl[0]  = mk(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 4'd0);
    tbl[1]  = mk(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd5, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 4'd0);
    tbl[2]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 3'd5, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 4'd0);
    tbl[3]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd1);
    tbl[4]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0, 3'd4, 3'd5, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 4'd1);
    tbl[5]  = mk(1'b1, 3'd4, 16'h0042, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4, 16'h0042, 1'b0, 16'h0042, 1'b0, 4'd0);
    tbl[6]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd4, 3'd3, 16'h0042, 1'b0, 16'h0000, 1'b0, 4'd0);
    tbl[7]  = mk(1'b1, 3'd6, 16'h7777, 1'b1, 3'd6, 1'b0, 3'd6, 3'd4, 16'h7777, 1'b0, 16'h0042, 1'b0, 4'd1);
    tbl[8]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd6, 3'd6, 16'h7777, 1'b1, 16'h7777, 1'b1, 4'd1);
    tbl[9]  = mk(1'b1, 3'd6, 16'h0066, 1'b1, 3'd0, 1'b0, 3'd0, 3'd6, 16'h0000, 1'b0, 16'h0066, 1'b0, 4'd0);
    tbl[10] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd1, 3'd6, 16'h0000, 1'b0, 16'h0066, 1'b0, 4'd1);
    tbl[11] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd2, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd2);
    tbl[12] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 1'b0, 3'd7, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd3);
    tbl[13] = mk(1'b1, 3'd1, 16'h0011, 1'b1, 3'd3, 1'b1, 3'd1, 3'd7, 16'h0011, 1'b0, 16'h0000, 1'b1, 4'd0);
    tbl[14] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd1, 3'd3, 16'h0011, 1'b0, 16'h0000, 1'b0, 4'd0);
    tbl[15] = mk(1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd7, 3'd2, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'd0);
    tbl[16] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd7, 3'd7, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 4'd0);

    rst_n = 1'b0;
    drive_idle();
    rd_addr_1 = 3'd3; rd_addr_2 = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", 0, {12'd0, busy_cnt}, 16'h0000);
    rst_n = 1'b1;

    // Async reset mid-cycle wipes data and busy state without a clock edge.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    claim_en = 1'b1; claim_addr = 3'd5;
    @(posedge clk);
    #1;
    drive_idle();
    check("pre_rst_data", 0, rd_data_1, 16'h1234);
    check("pre_rst_busy", 0, {15'd0, rd_busy_2}, 16'h0001);
    check("pre_rst_cnt", 0, {12'd0, busy_cnt}, 16'h0001);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 0, rd_data_1, 16'h0000);
    check("async_rst_busy", 0, {15'd0, rd_busy_2}, 16'h0000);
    check("async_rst_cnt", 0, {12'd0, busy_cnt}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(i, tbl[i]);
    end

    // busy_cnt climbs to its ceiling of NUM_REGS-1 with the zero register excluded.
    drive_idle();
    for (int i = 1; i < 8; i++) begin
      claim_en = 1'b1; claim_addr = 3'(i); rd_addr_1 = 3'(i);
      @(posedge clk);
      #1;
      check("fill_cnt", i, {12'd0, busy_cnt}, 16'(i));
      check("fill_busy", i, {15'd0, rd_busy_1}, 16'h0001);
    end
    claim_en = 1'b1; claim_addr = 3'd0;
    @(posedge clk);
    #1;
    check("fill_cnt_r0", 0, {12'd0, busy_cnt}, 16'h0007);
    flush = 1'b1; claim_addr = 3'd4;
    @(posedge clk);
    #1;
    drive_idle();
    check("flush_cnt", 0, {12'd0, busy_cnt}, 16'h0000);
    check("flush_busy", 0, {15'd0, rd_busy_1}, 16'h0000);

    // Without bypass the written value only appears after the edge.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5; rd_addr_1 = 3'd2;
    #1;
    check("byp_data", 0, rd_data_1, 16'hA5A5);
    check("nobyp_pre", 0, nb_data_1, 16'h0000);
    @(posedge clk);
    #1;
    drive_idle();
    check("nobyp_post", 0, nb_data_1, 16'hA5A5);
    check("nobyp_cnt", 0, {12'd0, nb_busy_cnt}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
